// File: rtl/vc_arb_pkg.sv
// Shared types and parameter defaults for the two-VC arbiter.
package vc_arb_pkg;

  localparam int unsigned DATA_WIDTH_DEF    = 6;
  localparam int unsigned MAX_VC0_BURST_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HALT   = 2'd2
  } arb_state_e;

  typedef enum logic {
    SEL_VC0 = 1'b0,
    SEL_VC1 = 1'b1
  } vc_sel_e;

endpackage

// File: rtl/vc_burst_counter.sv
// Saturating count of consecutive VC0 grants taken while VC1 is waiting.
module vc_burst_counter
  import vc_arb_pkg::*;
#(
  parameter int unsigned MAX_COUNT = MAX_VC0_BURST_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clear,
  output logic at_max_c
);

  localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(MAX_COUNT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_c = (cnt_q == CNT_W'(MAX_COUNT));

endmodule

// File: rtl/vc_arbiter.sv
// Strict-priority two-VC arbiter feeding one downstream FIFO with a halt-on-error FSM.
// Define VC1_STARVE_GUARD_EN to force a VC1 grant after MAX_VC0_BURST consecutive VC0 grants.
module vc_arbiter
  import vc_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned MAX_VC0_BURST = MAX_VC0_BURST_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in_VC0,
  input  logic [DATA_WIDTH-1:0] data_in_VC1,
  input  logic                  empty_VC0,
  input  logic                  empty_VC1,
  input  logic                  error_VC0,
  input  logic                  error_VC1,
  input  logic                  full_dest,
  input  logic                  almost_full_dest,
  output logic                  rd_enable_VC0,
  output logic                  rd_enable_VC1,
  output logic                  wr_enable_dest,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  arb_error
);

  if (MAX_VC0_BURST < 1) begin : g_bad_burst
    $error("MAX_VC0_BURST must be at least 1");
  end

  arb_state_e            state_q, state_d;
  logic                  wr_q, wr_d;
  vc_sel_e               sel_q, sel_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic                  pop_ok_c;
  logic                  force_vc1_c;
  logic                  grant0_c;
  logic                  grant1_c;
  logic [DATA_WIDTH-1:0] wr_word_c;

`ifdef VC1_STARVE_GUARD_EN
  logic at_max_c;

  vc_burst_counter #(
    .MAX_COUNT (MAX_VC0_BURST)
  ) u_burst (
    .clk      (clk),
    .reset    (reset),
    .inc      (grant0_c && !empty_VC1),
    .clear    (grant1_c || empty_VC1),
    .at_max_c (at_max_c)
  );

  assign force_vc1_c = at_max_c && !empty_VC1;
`else
  assign force_vc1_c = 1'b0;
`endif

  // Upstream FIFOs present the popped word one cycle after rd_enable.
  assign wr_word_c = (sel_q == SEL_VC1) ? data_in_VC1 : data_in_VC0;

  always_comb begin
    state_d  = state_q;
    wr_d     = 1'b0;
    sel_d    = sel_q;
    hold_d   = hold_q;
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    pop_ok_c = (state_q == ST_ACTIVE) && !full_dest && !almost_full_dest && !reset;

    if (pop_ok_c) begin
      if (!empty_VC1 && (force_vc1_c || empty_VC0)) begin
        grant1_c = 1'b1;
      end else if (!empty_VC0) begin
        grant0_c = 1'b1;
      end
    end

    if (grant1_c) begin
      wr_d  = 1'b1;
      sel_d = SEL_VC1;
    end else if (grant0_c) begin
      wr_d  = 1'b1;
      sel_d = SEL_VC0;
    end

    if (wr_q) begin
      hold_d = wr_word_c;
    end

    case (state_q)
      ST_IDLE:   state_d = ST_ACTIVE;
      ST_ACTIVE: if (error_VC0 || error_VC1) state_d = ST_HALT;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      sel_q   <= SEL_VC0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
    end
  end

  assign rd_enable_VC0  = grant0_c;
  assign rd_enable_VC1  = grant1_c;
  assign wr_enable_dest = wr_q;
  assign data_out       = wr_q ? wr_word_c : hold_q;
  assign arb_error      = (state_q == ST_HALT);

endmodule

// File: tb/tb_vc_arbiter.sv
// Randomised bench for vc_arbiter against a queue-based model of the arbitration rules.
module tb_vc_arbiter;

  localparam int unsigned DW   = 6;
  localparam int unsigned MAXB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in_VC0, data_in_VC1;
  logic          empty_VC0, empty_VC1, error_VC0, error_VC1;
  logic          full_dest, almost_full_dest;
  logic          rd_enable_VC0, rd_enable_VC1, wr_enable_dest, arb_error;
  logic [DW-1:0] data_out;

  always #5 clk = ~clk;

  vc_arbiter #(
    .DATA_WIDTH    (DW),
    .MAX_VC0_BURST (MAXB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data_in_VC0      (data_in_VC0),
    .data_in_VC1      (data_in_VC1),
    .empty_VC0        (empty_VC0),
    .empty_VC1        (empty_VC1),
    .error_VC0        (error_VC0),
    .error_VC1        (error_VC1),
    .full_dest        (full_dest),
    .almost_full_dest (almost_full_dest),
    .rd_enable_VC0    (rd_enable_VC0),
    .rd_enable_VC1    (rd_enable_VC1),
    .wr_enable_dest   (wr_enable_dest),
    .data_out         (data_out),
    .arb_error        (arb_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Upstream FIFO contents and observation logs
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            glog[$];
  logic [DW-1:0] wlog[$];

  // Model: 0 idle, 1 active, 2 halted
  int            m_state;
  bit            m_wr;
  logic [DW-1:0] m_out;
  int            m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clear_logs();
    glog.delete();
    wlog.delete();
  endtask

  // One clock cycle: drive flags, check every output against the model, advance FIFOs and model.
  task automatic cycle(input bit af, input bit full, input bit e0, input bit e1);
    bit allow, force1, g0, g1;
    int nstate, ncnt;
    @(negedge clk);
    empty_VC0        = (q0.size() == 0);
    empty_VC1        = (q1.size() == 0);
    almost_full_dest = af;
    full_dest        = full;
    error_VC0        = e0;
    error_VC1        = e1;
    #1;
    allow = (m_state == 1) && !af && !full;
`ifdef VC1_STARVE_GUARD_EN
    force1 = (m_cnt >= MAXB) && (q1.size() != 0);
`else
    force1 = 1'b0;
`endif
    g1 = allow && (q1.size() != 0) && (force1 || (q0.size() == 0));
    g0 = allow && (q0.size() != 0) && !g1;

    chk("rd_enable_VC0", 32'(rd_enable_VC0), 32'(g0));
    chk("rd_enable_VC1", 32'(rd_enable_VC1), 32'(g1));
    chk("wr_enable_dest", 32'(wr_enable_dest), 32'(m_wr));
    chk("data_out", 32'(data_out), 32'(m_out));
    chk("arb_error", 32'(arb_error), 32'(m_state == 2));

    glog.push_back(int'(rd_enable_VC0) + 2 * int'(rd_enable_VC1));
    if (wr_enable_dest) wlog.push_back(data_out);

    if (q1.size() == 0 || g1) ncnt = 0;
    else if (g0)              ncnt = m_cnt + 1;
    else                      ncnt = m_cnt;

    if (m_state == 0)                    nstate = 1;
    else if (m_state == 1 && (e0 || e1)) nstate = 2;
    else                                 nstate = m_state;

    @(posedge clk);
    #1;
    if (g0) begin
      data_in_VC0 = q0.pop_front();
      m_out       = data_in_VC0;
    end
    if (g1) begin
      data_in_VC1 = q1.pop_front();
      m_out       = data_in_VC1;
    end
    m_wr    = g0 || g1;
    m_state = nstate;
    m_cnt   = ncnt;
  endtask

  // Assert reset between edges, check the immediate clear, release between edges.
  task automatic async_reset(input int hold_cycles);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_wr_enable", 32'(wr_enable_dest), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_arb_error", 32'(arb_error), 32'h0);
    chk("rst_rd_enables", 32'({rd_enable_VC0, rd_enable_VC1}), 32'h0);
    m_state = 0;
    m_wr    = 1'b0;
    m_out   = '0;
    m_cnt   = 0;
    repeat (hold_cycles) @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic restart();
    async_reset(1);
    q0.delete();
    q1.delete();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    clear_logs();
  endtask

  task automatic fill(input int n0, input int n1);
    for (int i = 0; i < n0; i++) q0.push_back(DW'($urandom));
    for (int i = 0; i < n1; i++) q1.push_back(DW'($urandom));
  endtask

  initial begin
    reset            = 1'b1;
    data_in_VC0      = '0;
    data_in_VC1      = '0;
    empty_VC0        = 1'b1;
    empty_VC1        = 1'b1;
    error_VC0        = 1'b0;
    error_VC1        = 1'b0;
    full_dest        = 1'b0;
    almost_full_dest = 1'b0;
    m_state          = 0;
    m_wr             = 1'b0;
    m_out            = '0;
    m_cnt            = 0;

    #12;
    chk("init_wr_enable", 32'(wr_enable_dest), 32'h0);
    chk("init_data_out", 32'(data_out), 32'h0);
    chk("init_arb_error", 32'(arb_error), 32'h0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // VC0 priority with two queued words, VC1 also pending
    restart();
    q0.push_back(6'h0A);
    q0.push_back(6'h0B);
    q1.push_back(6'h21);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("prio_grant0", 32'(glog[0]), 32'h1);
    chk("prio_grant1", 32'(glog[1]), 32'h1);
    chk("prio_grant2", 32'(glog[2]), 32'h2);
    chk("prio_write0", 32'(wlog[0]), 32'h0A);
    chk("prio_write1", 32'(wlog[1]), 32'h0B);

    // VC0 empty, single VC1 word
    restart();
    q1.push_back(6'h15);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("vc1_grant", 32'(glog[0]), 32'h2);
    chk("vc1_nwrites", 32'(wlog.size()), 32'h1);
    chk("vc1_write", 32'(wlog[0]), 32'h15);

    // almost_full blocks pops; resumes the cycle it drops
    restart();
    fill(3, 3);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) chk("af_block", 32'(glog[i]), 32'h0);
    chk("af_resume", 32'(glog[3]), 32'h1);

    // Continuous contention: grant pattern depends on the starvation guard
    restart();
    fill(12, 4);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
`ifdef VC1_STARVE_GUARD_EN
      chk("burst_pattern", 32'(glog[i]), (i % 5 == 4) ? 32'h2 : 32'h1);
`else
      chk("burst_pattern", 32'(glog[i]), 32'h1);
`endif
    end

    // Error pulse mid-stream: in-flight word still written, then halted
    restart();
    fill(10, 0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_last_pop", 32'(glog[3]), 32'h1);
    for (int i = 4; i < 8; i++) chk("err_no_pop", 32'(glog[i]), 32'h0);
    chk("err_nwrites", 32'(wlog.size()), 32'h4);
    chk("err_sticky", 32'(arb_error), 32'h1);

    // Reset mid-stream: in-flight word dropped, no write after release
    restart();
    fill(6, 2);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    async_reset(2);
    clear_logs();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_no_write", 32'(wlog.size()), 32'h0);
    chk("rst_idle_pop", 32'(glog[0]), 32'h0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 8) q0.push_back(DW'($urandom));
      if ($urandom_range(0, 2) == 0 && q1.size() < 8) q1.push_back(DW'($urandom));
      if ((m_state == 2 && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0) begin
        async_reset($urandom_range(1, 2));
      end
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 199) == 0, $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 6, width of every data bus.
REQ-002 Parameter MAX_VC0_BURST, default 4, consecutive VC0 grants allowed while VC1 waits (starvation guard only).
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 data_in_VC0, data_in_VC1  in  DATA_WIDTH  registered data outputs of the two upstream VC FIFOs (valid one cycle after their rd_enable).
REQ-006 empty_VC0, empty_VC1  in  1  upstream FIFO empty flags.
REQ-007 error_VC0, error_VC1  in  1  upstream FIFO error flags.
REQ-008 full_dest, almost_full_dest  in  1  downstream FIFO full / almost-full flags.
REQ-009 rd_enable_VC0, rd_enable_VC1  out  1  pop strobes to upstream FIFOs.
REQ-010 wr_enable_dest  out  1  push strobe to downstream FIFO.
REQ-011 data_out  out  DATA_WIDTH  word pushed downstream.
REQ-012 arb_error  out  1  sticky fault indication.

Function
REQ-013 Shall implement a state machine: IDLE, ACTIVE, HALT.
REQ-014 IDLE -> ACTIVE on the first cycle after reset release; ACTIVE -> HALT when error_VC0 or error_VC1 is sampled 1; HALT is left only by reset.
REQ-015 In ACTIVE, a pop is allowed only when full_dest=0 and almost_full_dest=0.
REQ-016 Grant is strict priority: rd_enable_VC0=1 when allowed and empty_VC0=0; otherwise rd_enable_VC1=1 when allowed and empty_VC1=0; never both in one cycle.
REQ-017 rd_enable_* are combinational from current state, flags and burst counter; they shall be 0 in IDLE, HALT and while reset=1.
REQ-018 Pipeline: a pop in cycle N shall produce wr_enable_dest=1 in cycle N+1 with data_out equal to the granted FIFO's data_in in that cycle (registered select, one-cycle latency).
REQ-019 data_out shall hold its last value when wr_enable_dest=0.
REQ-020 Pop throughput: back-to-back pops every cycle while conditions of REQ-015/016 hold.
REQ-021 An in-flight word (popped in the cycle ACTIVE -> HALT is taken) shall still be written the next cycle; no new pops in HALT.
REQ-022 arb_error shall be 1 in HALT, 0 otherwise.

Reset
REQ-023 On reset assertion, state=IDLE, wr_enable_dest=0, data_out=0, arb_error=0, burst counter=0, pending-select register=0, immediately and without clock.
REQ-024 Reset mid-operation discards any in-flight word; no wr_enable_dest in the cycle after release.

Configuration
REQ-025 Macro VC1_STARVE_GUARD_EN: when defined, a counter counts consecutive VC0 grants while empty_VC1=0; when it reaches MAX_VC0_BURST, the next allowed pop shall go to VC1 (if non-empty) and the counter clears; the counter clears on any VC1 grant or when empty_VC1=1.
REQ-026 Without VC1_STARVE_GUARD_EN, no counter is built and strict priority of REQ-016 applies unconditionally.

Structure
REQ-027 Package vc_arb_pkg shall hold the state encoding typedef and defaults for DATA_WIDTH and MAX_VC0_BURST.
REQ-028 The burst counter shall be a sub-module vc_burst_counter, instantiated only under VC1_STARVE_GUARD_EN.

Verification
REQ-029 Both FIFOs non-empty, guard off, VC0 holds 0x0A,0x0B -> rd_enable_VC0 two cycles, wr_enable_dest next cycles with data_out 0x0A then 0x0B, rd_enable_VC1=0 throughout.
REQ-030 VC0 empty, VC1 holds 0x15 -> rd_enable_VC1 one cycle, data_out=0x15 one cycle later.
REQ-031 almost_full_dest=1 with both FIFOs non-empty -> no rd_enable for its duration; pops resume the cycle it drops.
REQ-032 Guard on, MAX_VC0_BURST=4, both non-empty continuously -> grant pattern VC0,VC0,VC0,VC0,VC1 repeating.
REQ-033 error_VC1 pulsed 1 cycle during streaming -> pending word written, then rd_enables 0 and arb_error=1 held until reset.
REQ-034 reset asserted asynchronously between clock edges mid-stream -> wr_enable_dest, data_out, arb_error go 0 immediately; no write in the first cycle after release.
